// File: rtl/avr_bus_master.sv
// AVR-side initiator for the CPLD SRAM bus.
// Shifts the address out serially, then runs a ce/oe/we strobe.
module avr_bus_master #(
  parameter int ADDR_WIDTH    = 21,
  parameter int DATA_WIDTH    = 8,
  parameter int SCK_DIV       = 1,
  parameter int STROBE_CYCLES = 4
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  avr_si,
  output logic                  avr_sreg_clk,
  output logic                  avr_ce,
  output logic                  avr_oe,
  output logic                  avr_we,
  output logic [DATA_WIDTH-1:0] avr_data_out,
  output logic                  avr_data_oe,
  input  logic [DATA_WIDTH-1:0] avr_data_in
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(ADDR_WIDTH - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] sr;
  logic                  we_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DW-1:0]         div_cnt;
  logic                  phase;
  logic [BW-1:0]         bit_cnt;
  logic [SW-1:0]         stb_cnt;

  logic accept;
  logic div_end;
  logic bit_last;
  logic shift_end;
  logic stb_end;

  assign accept    = cmd_valid & (state == IDLE);
  assign div_end   = (div_cnt == DIV_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign shift_end = phase & div_end & bit_last;
  assign stb_end   = (stb_cnt == STB_LAST);

  // State register; reset aborts any command in flight.
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command latch, shift divider/bit counter, strobe timer, read capture.
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      sr        <= '0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      stb_cnt   <= '0;
      rsp_rdata <= '0;
    end else if (accept) begin
      sr      <= cmd_addr;
      we_r    <= cmd_we;
      wdata_r <= cmd_wdata;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      stb_cnt <= '0;
    end else if (state == SHIFT) begin
      if (div_end) begin
        div_cnt <= '0;
        phase   <= ~phase;
        if (phase) begin
          sr <= {sr[ADDR_WIDTH-2:0], 1'b0};
          if (!bit_last) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else if (state == STROBE) begin
      if (stb_end) begin
        if (!we_r) begin
          rsp_rdata <= avr_data_in;
        end
      end else begin
        stb_cnt <= stb_cnt + 1'b1;
      end
    end
  end

  // Next state and pin decode from the current state.
  always_comb begin
    state_nx     = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    avr_si       = 1'b0;
    avr_sreg_clk = 1'b0;
    avr_ce       = 1'b1;
    avr_oe       = 1'b1;
    avr_we       = 1'b1;
    avr_data_oe  = 1'b0;
    avr_data_out = '0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        avr_si       = sr[ADDR_WIDTH-1];
        avr_sreg_clk = phase;
        if (shift_end) begin
          state_nx = SETUP;
        end
      end
      SETUP: begin
        avr_ce       = 1'b0;
        avr_data_oe  = we_r;
        avr_data_out = we_r ? wdata_r : '0;
        state_nx     = STROBE;
      end
      STROBE: begin
        avr_ce       = 1'b0;
        avr_oe       = we_r;
        avr_we       = ~we_r;
        avr_data_oe  = we_r;
        avr_data_out = we_r ? wdata_r : '0;
        if (stb_end) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        avr_ce       = 1'b0;
        avr_data_oe  = we_r;
        avr_data_out = we_r ? wdata_r : '0;
        state_nx     = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_avr_bus_master.sv
// Bench for avr_bus_master: default and SCK_DIV=2/STROBE=1 instances.
// A pin-level monitor decodes each bus cycle and checks it against a queue.
module tb_avr_bus_master;

  typedef struct {
    logic        we;
    logic [20:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] cv, cr, cwe, rv, si, sck, ce, oe, we, doe;
  logic [1:0][20:0] ca;
  logic [1:0][7:0] cwd, rd, dout, din;
  logic [7:0] rd0, rd1;

  assign din[0] = oe[0] ? 8'h00 : rd0;
  assign din[1] = oe[1] ? 8'h00 : rd1;

  avr_bus_master u0 (
    .avr_clk(clk), .avr_reset(rst),
    .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .cmd_we(cwe[0]), .cmd_addr(ca[0]),
    .cmd_wdata(cwd[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .avr_si(si[0]), .avr_sreg_clk(sck[0]),
    .avr_ce(ce[0]), .avr_oe(oe[0]),
    .avr_we(we[0]),
    .avr_data_out(dout[0]),
    .avr_data_oe(doe[0]),
    .avr_data_in(din[0])
  );

  avr_bus_master #(
    .SCK_DIV(2), .STROBE_CYCLES(1)
  ) u1 (
    .avr_clk(clk), .avr_reset(rst),
    .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .cmd_we(cwe[1]), .cmd_addr(ca[1]),
    .cmd_wdata(cwd[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .avr_si(si[1]), .avr_sreg_clk(sck[1]),
    .avr_ce(ce[1]), .avr_oe(oe[1]),
    .avr_we(we[1]),
    .avr_data_out(dout[1]),
    .avr_data_oe(doe[1]),
    .avr_data_in(din[1])
  );

  int nvec = 0;
  int nmis = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t em;

  logic [7:0] exp_rd [2];
  logic [7:0] sram [logic [20:0]];
  logic [7:0] refm [logic [20:0]];

  logic [1:0] act, prv, sil, bad_s, bad_i, dany, chk_r;
  int age [2];
  int nb [2];
  int run [2];
  int oen [2];
  int wen [2];
  logic [20:0] sh [2];
  logic [7:0] wd [2];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dv(input int g);
    return (g != 0) ? 2 : 1;
  endfunction

  function automatic int stb(input int g);
    return (g != 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [23:0] pins(input int g);
    return {cr[g], rv[g], si[g], sck[g], ce[g], oe[g],
            we[g], doe[g], dout[g], rd[g]};
  endfunction

  // Pin monitor: sampled mid-cycle, one bus cycle per accept.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        act[g]   = 1'b0;
        chk_r[g] = 1'b0;
      end else if (act[g]) begin
        age[g]++;
        if (sck[g] != prv[g]) begin
          if (run[g] != dv(g)) bad_s[g] = 1'b1;
          run[g] = 1;
          if (sck[g]) begin
            sh[g]  = {sh[g][19:0], si[g]};
            nb[g]++;
            sil[g] = si[g];
          end
        end else begin
          run[g]++;
        end
        prv[g] = sck[g];
        if (sck[g] && si[g] !== sil[g]) bad_s[g] = 1'b1;
        if (nb[g] == 21 && !sck[g] && si[g]) bad_s[g] = 1'b1;
        if (g == 1 && nb[g] == 21)
          rd1 = sram.exists(sh[1]) ? sram[sh[1]] : dflt(sh[1]);
        if (!oe[g]) oen[g]++;
        if (!we[g]) begin
          wen[g]++;
          wd[g] = dout[g];
          if (g == 1) sram[sh[1]] = dout[1];
        end
        if (doe[g]) dany[g] = 1'b1;
        if ((!oe[g] && !we[g]) || (doe[g] && !oe[g]) ||
            ((!oe[g] || !we[g]) && ce[g]) ||
            (cr[g] && !rv[g]))
          bad_i[g] = 1'b1;
        if (rv[g]) begin
          act[g]   = 1'b0;
          chk_r[g] = 1'b1;
          if ((g == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            if (g == 0) em = sb0.pop_front();
            else        em = sb1.pop_front();
            chk("lat", age[g], em.lat);
            chk("nbits", nb[g], 21);
            chk("addr", sh[g], em.addr);
            chk("oe_cyc", oen[g], em.we ? 0 : stb(g));
            chk("we_cyc", wen[g], em.we ? stb(g) : 0);
            if (em.we) chk("wdata", wd[g], em.wdata);
            chk("data_oe", dany[g], em.we);
            chk("rdata", rd[g], em.rdata);
            chk("sck_tim", bad_s[g], 0);
            chk("invar", bad_i[g], 0);
          end
        end
      end else begin
        if (chk_r[g]) begin
          chk("rdy_after", {cr[g], rv[g]}, 2'b10);
          chk_r[g] = 1'b0;
        end else if (rv[g]) begin
          chk("spur_rsp", rv[g], 1'b0);
        end
        if (cv[g] && cr[g]) begin
          act[g]   = 1'b1;
          age[g]   = -1;
          nb[g]    = 0;
          run[g]   = 0;
          oen[g]   = 0;
          wen[g]   = 0;
          sh[g]    = '0;
          wd[g]    = '0;
          prv[g]   = 1'b0;
          sil[g]   = 1'b0;
          bad_s[g] = 1'b0;
          bad_i[g] = 1'b0;
          dany[g]  = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int g, input logic w,
                       input logic [20:0] a,
                       input logic [7:0] d,
                       input logic [7:0] rdv,
                       input bit hold);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    while (!cr[g] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_wait", cr[g], 1'b1);
    if (w) begin
      if (g == 1) refm[a] = d;
    end else if (g == 0) begin
      rd0 = rdv;
      exp_rd[0] = rdv;
    end else begin
      exp_rd[1] = refm.exists(a) ? refm[a] : dflt(a);
    end
    e.we    = w;
    e.addr  = a;
    e.wdata = d;
    e.rdata = exp_rd[g];
    e.lat   = (g != 0) ? 87 : 48;
    if (g == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    cwe[g] = w;
    ca[g]  = a;
    cwd[g] = d;
    cv[g]  = 1'b1;
    @(posedge clk); #1;
    if (!hold) cv[g] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb0.size() + sb1.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic w;
    logic [20:0] a;
    rst = 1'b1;
    cv = '0; cwe = '0; ca = '0; cwd = '0;
    rd0 = 8'h00; rd1 = 8'h00;
    act = '0; chk_r = '0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins0", pins(0), 24'h8E0000);
    chk("rst_pins1", pins(1), 24'h8E0000);
    rst = 1'b0;

    issue(0, 1'b1, 21'h155AA, 8'hEE, 8'h00, 1'b0);
    drain();
    issue(0, 1'b0, 21'h00003, 8'h00, 8'hAA, 1'b0);
    drain();

    issue(0, 1'b1, 21'h1FFFFF, 8'h55, 8'h00, 1'b1);
    issue(0, 1'b0, 21'h000000, 8'h00, 8'h5A, 1'b0);
    drain();

    issue(0, 1'b1, 21'h0ABCD, 8'h12, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_rdy", cr[0], 1'b0);
    cwe[0] = 1'b0;
    ca[0]  = 21'h1F0F0;
    cv[0]  = 1'b1;
    @(posedge clk); #1;
    cv[0]  = 1'b0;
    drain();

    issue(0, 1'b1, 21'h12345, 8'h77, 8'h00, 1'b0);
    n = 0;
    while (nb[0] < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bits_seen", nb[0] >= 10, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_pins", pins(0), 24'h8E0000);
    sb0.delete();
    exp_rd[0] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    issue(0, 1'b0, 21'h1ABCD, 8'h00, 8'hC3, 1'b0);
    drain();

    for (int i = 0; i < 16; i++) begin
      w = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      a = 21'h10000 | 21'($urandom_range(0, 7));
      issue(1, w, a, 8'($urandom), 8'h00, 1'b0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
